// File: rtl/multi_lane_link_ctrl.sv
// multi_lane_link_ctrl: per-lane link bring-up supervisor for an N-lane 10G PHY.
// It drives the global TX soft reset and the per-lane RX soft resets, waits for
// the GT reset FSMs to finish, and qualifies each lane on stable data_valid. It
// retries on timeout or loss of lock, and it reports lane-up, link-up and failure.
// Optional build macro TENG_LINK_STATS_EN adds per-lane 16-bit drop counters on
// the drop_cnt_o port.
module multi_lane_link_ctrl #(
    parameter int NUMBER_OF_LANES = 2,
    parameter int RST_CYCLES      = 16,
    parameter int TIMEOUT_CYCLES  = 50000,
    parameter int STABLE_CYCLES   = 1024,
    parameter int LOSS_CYCLES     = 64,
    parameter int MAX_RETRY       = 15
) (
    input  logic                               sys_clk_i,
    input  logic                               sys_rst_i,
    input  logic                               restart_i,
    input  logic [NUMBER_OF_LANES-1:0]         lane_en_i,
    input  logic [NUMBER_OF_LANES-1:0]         tx_rst_done_i,
    input  logic [NUMBER_OF_LANES-1:0]         rx_rst_done_i,
    input  logic [NUMBER_OF_LANES-1:0]         data_valid_i,
    output logic                               soft_reset_tx_o,
    output logic [NUMBER_OF_LANES-1:0]         soft_reset_rx_o,
    output logic [NUMBER_OF_LANES-1:0]         lane_up_o,
    output logic                               link_up_o,
    output logic                               link_fail_o,
    output logic [$clog2(MAX_RETRY+1)-1:0]     retry_cnt_o
`ifdef TENG_LINK_STATS_EN
    ,
    output logic [16*NUMBER_OF_LANES-1:0]      drop_cnt_o
`endif
);

    localparam int N       = NUMBER_OF_LANES;
    localparam int RW      = $clog2(MAX_RETRY + 1);
    localparam int MAX_AB  = (RST_CYCLES > TIMEOUT_CYCLES) ? RST_CYCLES : TIMEOUT_CYCLES;
    localparam int MAX_CD  = (STABLE_CYCLES > LOSS_CYCLES) ? STABLE_CYCLES : LOSS_CYCLES;
    localparam int MAX_CNT = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW      = $clog2(MAX_CNT + 1);

    localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] LOSS_LAST    = CW'(LOSS_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        G_IDLE, G_TXRST, G_TXWAIT, G_RUN, G_FAIL
    } global_state_t;

    typedef enum logic [2:0] {
        L_IDLE, L_RST, L_WAIT, L_CHECK, L_UP
    } lane_state_t;

    global_state_t  g_state;
    logic [CW-1:0]  g_cnt;
    lane_state_t    l_state [N];
    logic [CW-1:0]  l_cnt   [N];

    logic [N-1:0] tx_meta, tx_sync;
    logic [N-1:0] rx_meta, rx_sync;
    logic [N-1:0] dv_meta, dv_sync;

    logic         all_tx_done;
    logic         g_tx_timeout;
    logic         g_tx_drop;
    logic [N-1:0] lane_timeout;
    logic [N-1:0] lane_loss;
    logic         retry_event;
    logic         fail_entry;
    logic         lanes_abort;

    // Two-flop synchronisers for the asynchronous PHY status inputs.
    // NOTE: the first stage may go metastable; nothing but the second stage reads it.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            tx_meta <= '0;
            tx_sync <= '0;
            rx_meta <= '0;
            rx_sync <= '0;
            dv_meta <= '0;
            dv_sync <= '0;
        end else begin
            tx_meta <= tx_rst_done_i;
            tx_sync <= tx_meta;
            rx_meta <= rx_rst_done_i;
            rx_sync <= rx_meta;
            dv_meta <= data_valid_i;
            dv_sync <= dv_meta;
        end
    end

    // Retry events from the global and lane FSMs, merged into one increment per cycle.
    // NOTE: every signal gets a default at the top, so no latch is inferred.
    always_comb begin
        lane_timeout = '0;
        lane_loss    = '0;
        all_tx_done  = &(tx_sync | ~lane_en_i);
        g_tx_timeout = (g_state == G_TXWAIT) && !all_tx_done && (g_cnt == TIMEOUT_LAST);
        g_tx_drop    = (g_state == G_RUN) && |(~tx_sync & lane_en_i);
        for (int l = 0; l < N; l++) begin
            lane_timeout[l] = (g_state == G_RUN) && lane_en_i[l] && (l_state[l] == L_WAIT) &&
                              !rx_sync[l] && (l_cnt[l] == TIMEOUT_LAST);
            lane_loss[l]    = (g_state == G_RUN) && lane_en_i[l] && (l_state[l] == L_UP) &&
                              !dv_sync[l] && (l_cnt[l] == LOSS_LAST);
        end
        retry_event = g_tx_timeout || g_tx_drop || (|lane_timeout) || (|lane_loss);
        // A retry while the counter is saturated ends the bring-up attempt.
        fail_entry  = retry_event && (retry_cnt_o == RETRY_MAX) && !restart_i;
        // Lanes leave RUN on the same edge that the global FSM does.
        lanes_abort = g_tx_drop || fail_entry;
    end

    // Global FSM: TX reset sequencing, retry accounting and the fail state.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i || restart_i) begin
            g_state         <= G_IDLE;
            g_cnt           <= '0;
            retry_cnt_o     <= '0;
            soft_reset_tx_o <= 1'b0;
            link_fail_o     <= 1'b0;
        end else if (fail_entry) begin
            g_state         <= G_FAIL;
            g_cnt           <= '0;
            soft_reset_tx_o <= 1'b1;
            link_fail_o     <= 1'b1;
        end else begin
            if (retry_event) begin
                retry_cnt_o <= retry_cnt_o + 1'b1;
            end
            case (g_state)
                G_IDLE: begin
                    if (|lane_en_i) begin
                        g_state         <= G_TXRST;
                        g_cnt           <= '0;
                        soft_reset_tx_o <= 1'b1;
                    end
                end
                G_TXRST: begin
                    if (g_cnt == RST_LAST) begin
                        g_state         <= G_TXWAIT;
                        g_cnt           <= '0;
                        soft_reset_tx_o <= 1'b0;
                    end else begin
                        g_cnt <= g_cnt + 1'b1;
                    end
                end
                G_TXWAIT: begin
                    if (all_tx_done) begin
                        g_state <= G_RUN;
                        g_cnt   <= '0;
                    end else if (g_tx_timeout) begin
                        g_state         <= G_TXRST;
                        g_cnt           <= '0;
                        soft_reset_tx_o <= 1'b1;
                    end else begin
                        g_cnt <= g_cnt + 1'b1;
                    end
                end
                G_RUN: begin
                    if (g_tx_drop) begin
                        g_state         <= G_TXRST;
                        g_cnt           <= '0;
                        soft_reset_tx_o <= 1'b1;
                    end
                end
                G_FAIL: begin
                    soft_reset_tx_o <= 1'b1;
                    link_fail_o     <= 1'b1;
                end
                default: g_state <= G_IDLE;
            endcase
        end
    end

    // Lane FSMs: RX reset, reset-done wait, data_valid qualification and loss detection.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            soft_reset_rx_o <= '0;
            lane_up_o       <= '0;
            for (int l = 0; l < N; l++) begin
                l_state[l] <= L_IDLE;
                l_cnt[l]   <= '0;
            end
        end else begin
            for (int l = 0; l < N; l++) begin
                if (restart_i || (g_state != G_RUN) || lanes_abort || !lane_en_i[l]) begin
                    l_state[l]         <= L_IDLE;
                    l_cnt[l]           <= '0;
                    lane_up_o[l]       <= 1'b0;
                    soft_reset_rx_o[l] <= !lane_en_i[l] ||
                                          (!restart_i && (fail_entry || (g_state == G_FAIL)));
                end else begin
                    case (l_state[l])
                        L_IDLE: begin
                            l_state[l]         <= L_RST;
                            l_cnt[l]           <= '0;
                            soft_reset_rx_o[l] <= 1'b1;
                        end
                        L_RST: begin
                            if (l_cnt[l] == RST_LAST) begin
                                l_state[l]         <= L_WAIT;
                                l_cnt[l]           <= '0;
                                soft_reset_rx_o[l] <= 1'b0;
                            end else begin
                                l_cnt[l] <= l_cnt[l] + 1'b1;
                            end
                        end
                        L_WAIT: begin
                            if (rx_sync[l]) begin
                                l_state[l] <= L_CHECK;
                                l_cnt[l]   <= '0;
                            end else if (lane_timeout[l]) begin
                                l_state[l]         <= L_RST;
                                l_cnt[l]           <= '0;
                                soft_reset_rx_o[l] <= 1'b1;
                            end else begin
                                l_cnt[l] <= l_cnt[l] + 1'b1;
                            end
                        end
                        L_CHECK: begin
                            // rx_rst_done was high on entry, so a low here is a falling edge.
                            if (!rx_sync[l]) begin
                                l_state[l]         <= L_RST;
                                l_cnt[l]           <= '0;
                                soft_reset_rx_o[l] <= 1'b1;
                            end else if (!dv_sync[l]) begin
                                l_cnt[l] <= '0;
                            end else if (l_cnt[l] == STABLE_LAST) begin
                                l_state[l]   <= L_UP;
                                l_cnt[l]     <= '0;
                                lane_up_o[l] <= 1'b1;
                            end else begin
                                l_cnt[l] <= l_cnt[l] + 1'b1;
                            end
                        end
                        L_UP: begin
                            if (lane_loss[l]) begin
                                l_state[l]         <= L_RST;
                                l_cnt[l]           <= '0;
                                lane_up_o[l]       <= 1'b0;
                                soft_reset_rx_o[l] <= 1'b1;
                            end else if (!dv_sync[l]) begin
                                l_cnt[l] <= l_cnt[l] + 1'b1;
                            end else begin
                                l_cnt[l] <= '0;
                            end
                        end
                        default: l_state[l] <= L_IDLE;
                    endcase
                end
            end
        end
    end

    // Link-up: every enabled lane is up while the global FSM runs.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i || restart_i) begin
            link_up_o <= 1'b0;
        end else begin
            link_up_o <= (g_state == G_RUN) && (|lane_en_i) && (&(lane_up_o | ~lane_en_i));
        end
    end

`ifdef TENG_LINK_STATS_EN
    logic [15:0] drop_cnt [N];

    // Per-lane saturating count of L_UP -> L_RST drops.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i || restart_i) begin
            for (int l = 0; l < N; l++) begin
                drop_cnt[l] <= '0;
            end
        end else begin
            for (int l = 0; l < N; l++) begin
                if (lane_loss[l] && !fail_entry && (drop_cnt[l] != 16'hFFFF)) begin
                    drop_cnt[l] <= drop_cnt[l] + 16'd1;
                end
            end
        end
    end

    // Flatten the per-lane counters onto the output bus.
    always_comb begin
        drop_cnt_o = '0;
        for (int l = 0; l < N; l++) begin
            drop_cnt_o[16*l +: 16] = drop_cnt[l];
        end
    end
`endif

endmodule

// File: tb/tb_multi_lane_link_ctrl.sv
// Directed testbench for multi_lane_link_ctrl. It contains a small PHY model in
// which each reset_done rises 20 cycles after its soft reset is released.
module tb_multi_lane_link_ctrl;

    localparam int PHY_DELAY = 20;

    logic       clk = 1'b0;
    logic       sys_rst;
    logic       restart;
    logic [1:0] lane_en;
    logic [1:0] tx_rst_done;
    logic [1:0] rx_rst_done;
    logic [1:0] data_valid;
    logic       soft_reset_tx_o;
    logic [1:0] soft_reset_rx_o;
    logic [1:0] lane_up_o;
    logic       link_up_o;
    logic       link_fail_o;
    logic [1:0] retry_cnt_o;
`ifdef TENG_LINK_STATS_EN
    logic [31:0] drop_cnt_o;
`endif

    logic       tx_block;
    logic [1:0] rx_block;
    int         tx_ctr;
    int         rx_ctr [2];
    int         total;
    int         bad;

    always #5 clk = ~clk;

    multi_lane_link_ctrl #(
        .NUMBER_OF_LANES(2),
        .RST_CYCLES(16),
        .TIMEOUT_CYCLES(100),
        .STABLE_CYCLES(32),
        .LOSS_CYCLES(64),
        .MAX_RETRY(3)
    ) dut (
        .sys_clk_i(clk),
        .sys_rst_i(sys_rst),
        .restart_i(restart),
        .lane_en_i(lane_en),
        .tx_rst_done_i(tx_rst_done),
        .rx_rst_done_i(rx_rst_done),
        .data_valid_i(data_valid),
        .soft_reset_tx_o(soft_reset_tx_o),
        .soft_reset_rx_o(soft_reset_rx_o),
        .lane_up_o(lane_up_o),
        .link_up_o(link_up_o),
        .link_fail_o(link_fail_o),
        .retry_cnt_o(retry_cnt_o)
`ifdef TENG_LINK_STATS_EN
        ,
        .drop_cnt_o(drop_cnt_o)
`endif
    );

    // PHY model: each reset_done rises PHY_DELAY cycles after its soft reset is released.
    always @(negedge clk) begin
        if (soft_reset_tx_o || tx_block) begin
            tx_ctr      = 0;
            tx_rst_done = 2'b00;
        end else if (tx_ctr < PHY_DELAY) begin
            tx_ctr++;
        end else begin
            tx_rst_done = 2'b11;
        end
        for (int l = 0; l < 2; l++) begin
            if (soft_reset_rx_o[l] || rx_block[l]) begin
                rx_ctr[l]      = 0;
                rx_rst_done[l] = 1'b0;
            end else if (rx_ctr[l] < PHY_DELAY) begin
                rx_ctr[l]++;
            end else begin
                rx_rst_done[l] = 1'b1;
            end
        end
    end

    task automatic do_reset(input logic [1:0] en);
        sys_rst = 1'b1;
        lane_en = en;
        repeat (3) @(negedge clk);
        sys_rst = 1'b0;
    endtask

    task automatic wait_link_up(input int bound, input string name);
        int c;
        c = 0;
        while (!link_up_o && c < bound) begin
            @(negedge clk);
            c++;
        end
        total++;
        if (link_up_o !== 1'b1) begin
            bad++;
            $display("FAIL %s: link_up_o=%b after %0d cycles, required 1", name, link_up_o, c);
        end
    endtask

    task automatic test_reset;
        sys_rst = 1'b1;
        lane_en = 2'b00;
        repeat (3) @(negedge clk);
        total++;
        if ({soft_reset_tx_o, soft_reset_rx_o, lane_up_o, link_up_o, link_fail_o, retry_cnt_o} !== 9'd0) begin
            bad++;
            $display("FAIL reset_outputs: tx=%b rx=%b up=%b link=%b fail=%b retry=%0d, required all 0",
                     soft_reset_tx_o, soft_reset_rx_o, lane_up_o, link_up_o, link_fail_o, retry_cnt_o);
        end
        sys_rst = 1'b0;
        repeat (5) @(negedge clk);
        total++;
        if (soft_reset_tx_o !== 1'b0 || soft_reset_rx_o !== 2'b11) begin
            bad++;
            $display("FAIL idle_no_lanes: tx=%b rx=%b, required tx=0 rx=11", soft_reset_tx_o, soft_reset_rx_o);
        end
    endtask

    task automatic test_bringup;
        int c;
        int width;
        logic both;
        lane_en = 2'b11;
        c = 0;
        while (!soft_reset_tx_o && c < 10) begin
            @(negedge clk);
            c++;
        end
        width = 0;
        while (soft_reset_tx_o && width < 40) begin
            @(negedge clk);
            width++;
        end
        total++;
        if (width != 16) begin
            bad++;
            $display("FAIL tx_pulse_width: got %0d cycles, required 16", width);
        end
        c = 0;
        while (!soft_reset_rx_o[0] && c < 100) begin
            @(negedge clk);
            c++;
        end
        width = 0;
        both  = 1'b1;
        while (soft_reset_rx_o[0] && width < 40) begin
            if (soft_reset_rx_o !== 2'b11) both = 1'b0;
            @(negedge clk);
            width++;
        end
        total++;
        if (width != 16 || !both) begin
            bad++;
            $display("FAIL rx_pulse_width: got %0d cycles both_lanes=%b, required 16 and 1", width, both);
        end
        c = 0;
        while (!link_up_o && c < 200) begin
            @(negedge clk);
            c++;
        end
        total++;
        if (c < 54 || c > 60) begin
            bad++;
            $display("FAIL link_up_latency: got %0d cycles after rx release, required 54..60", c);
        end
        total++;
        if (lane_up_o !== 2'b11 || retry_cnt_o !== 2'd0 || link_fail_o !== 1'b0) begin
            bad++;
            $display("FAIL bringup_status: up=%b retry=%0d fail=%b, required 11 0 0", lane_up_o, retry_cnt_o, link_fail_o);
        end
    endtask

    // Holds lane 1 data_valid low for low_cycles and watches the lanes for 170 cycles.
    task automatic run_loss(input int low_cycles, output logic drop1, output logic lane0_ok,
                            output int rx1_width, output logic link_dropped);
        drop1        = 1'b0;
        lane0_ok     = 1'b1;
        rx1_width    = 0;
        link_dropped = 1'b0;
        for (int i = 0; i < 170; i++) begin
            @(negedge clk);
            data_valid[1] = (i < low_cycles) ? 1'b0 : 1'b1;
            if (!lane_up_o[1]) drop1 = 1'b1;
            if (!lane_up_o[0] || soft_reset_rx_o[0]) lane0_ok = 1'b0;
            if (soft_reset_rx_o[1]) rx1_width++;
            if (!link_up_o) link_dropped = 1'b1;
        end
    endtask

    task automatic test_loss_63;
        logic drop1, lane0_ok, link_dropped;
        int   rx1_width;
        run_loss(63, drop1, lane0_ok, rx1_width, link_dropped);
        total++;
        if (drop1 || link_dropped || rx1_width != 0 || retry_cnt_o !== 2'd0) begin
            bad++;
            $display("FAIL loss_63_stays_up: drop=%b link_dropped=%b rx1=%0d retry=%0d, required 0 0 0 0",
                     drop1, link_dropped, rx1_width, retry_cnt_o);
        end
    endtask

    task automatic test_loss_64;
        logic drop1, lane0_ok, link_dropped;
        int   rx1_width;
        run_loss(64, drop1, lane0_ok, rx1_width, link_dropped);
        total++;
        if (!drop1 || !link_dropped || rx1_width != 16) begin
            bad++;
            $display("FAIL loss_64_drops: drop=%b link_dropped=%b rx1_width=%0d, required 1 1 16",
                     drop1, link_dropped, rx1_width);
        end
        total++;
        if (!lane0_ok) begin
            bad++;
            $display("FAIL loss_64_lane0: lane0 disturbed=1, required 0");
        end
        total++;
        if (retry_cnt_o !== 2'd1) begin
            bad++;
            $display("FAIL loss_64_retry: got %0d, required 1", retry_cnt_o);
        end
        wait_link_up(300, "loss_64_recover");
    endtask

`ifdef TENG_LINK_STATS_EN
    task automatic test_stats;
        total++;
        if (drop_cnt_o !== 32'h0001_0000) begin
            bad++;
            $display("FAIL stats_after_loss: got %h, required 00010000", drop_cnt_o);
        end
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        total++;
        if (drop_cnt_o !== 32'h0 || retry_cnt_o !== 2'd0) begin
            bad++;
            $display("FAIL stats_clear: drop=%h retry=%0d, required 0 0", drop_cnt_o, retry_cnt_o);
        end
        wait_link_up(400, "stats_bringup");
        for (int k = 0; k < 3; k++) begin
            data_valid[0] = 1'b0;
            repeat (70) @(negedge clk);
            data_valid[0] = 1'b1;
            wait_link_up(300, "stats_drop_recover");
        end
        total++;
        if (drop_cnt_o[15:0] !== 16'd3 || drop_cnt_o[31:16] !== 16'd0 || retry_cnt_o !== 2'd3 || link_fail_o !== 1'b0) begin
            bad++;
            $display("FAIL stats_three_drops: drop=%h retry=%0d fail=%b, required 00000003 3 0",
                     drop_cnt_o, retry_cnt_o, link_fail_o);
        end
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        total++;
        if (drop_cnt_o !== 32'h0) begin
            bad++;
            $display("FAIL stats_restart_clear: got %h, required 0", drop_cnt_o);
        end
    endtask
`endif

    task automatic test_lane_mask;
        int   c;
        logic rx1_held;
        rx_block = 2'b10;
        do_reset(2'b01);
        rx1_held = 1'b1;
        c = 0;
        while (!link_up_o && c < 400) begin
            @(negedge clk);
            c++;
            if (soft_reset_rx_o[1] !== 1'b1) rx1_held = 1'b0;
        end
        total++;
        if (link_up_o !== 1'b1 || lane_up_o !== 2'b01) begin
            bad++;
            $display("FAIL mask_link_up: link=%b up=%b, required 1 01", link_up_o, lane_up_o);
        end
        total++;
        if (!rx1_held) begin
            bad++;
            $display("FAIL mask_rx1_held: soft_reset_rx[1] dropped=1, required held high");
        end
        rx_block = 2'b00;
    endtask

    task automatic test_timeout_fail;
        int   pulses;
        int   low_run;
        int   high_run;
        logic prev;
        logic gaps_ok;
        logic widths_ok;
        logic held;
        tx_block = 1'b1;
        do_reset(2'b11);
        prev      = soft_reset_tx_o;
        pulses    = 0;
        low_run   = 0;
        high_run  = 0;
        gaps_ok   = 1'b1;
        widths_ok = 1'b1;
        for (int c = 0; c < 1000 && !link_fail_o; c++) begin
            @(negedge clk);
            if (soft_reset_tx_o) begin
                if (!prev) begin
                    if (pulses > 0 && low_run != 100) gaps_ok = 1'b0;
                    if (!link_fail_o) pulses++;
                    high_run = 0;
                end
                high_run++;
                low_run = 0;
            end else begin
                if (prev && high_run != 16) widths_ok = 1'b0;
                low_run++;
            end
            prev = soft_reset_tx_o;
        end
        total++;
        if (link_fail_o !== 1'b1 || pulses != 4 || retry_cnt_o !== 2'd3) begin
            bad++;
            $display("FAIL timeout_fail: fail=%b pulses=%0d retry=%0d, required 1 4 3", link_fail_o, pulses, retry_cnt_o);
        end
        total++;
        if (!gaps_ok || !widths_ok) begin
            bad++;
            $display("FAIL timeout_spacing: gaps_ok=%b widths_ok=%b, required 1 1", gaps_ok, widths_ok);
        end
        held = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (soft_reset_tx_o !== 1'b1 || soft_reset_rx_o !== 2'b11 || link_fail_o !== 1'b1) held = 1'b0;
        end
        total++;
        if (!held) begin
            bad++;
            $display("FAIL fail_hold: resets and fail held=%b, required 1", held);
        end
    endtask

    task automatic test_restart_in_fail;
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        total++;
        if (link_fail_o !== 1'b0 || retry_cnt_o !== 2'd0 || soft_reset_tx_o !== 1'b0 || soft_reset_rx_o !== 2'b00) begin
            bad++;
            $display("FAIL restart_clear: fail=%b retry=%0d tx=%b rx=%b, required 0 0 0 00",
                     link_fail_o, retry_cnt_o, soft_reset_tx_o, soft_reset_rx_o);
        end
        @(negedge clk);
        total++;
        if (soft_reset_tx_o !== 1'b1) begin
            bad++;
            $display("FAIL restart_new_pulse: tx=%b, required 1", soft_reset_tx_o);
        end
    endtask

    task automatic test_restart_vs_timeout;
        int c;
        c = 0;
        while (soft_reset_tx_o && c < 40) begin
            @(negedge clk);
            c++;
        end
        // The timeout edge is the 100th rising edge after this sample.
        repeat (99) @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        total++;
        if (soft_reset_tx_o !== 1'b0 || retry_cnt_o !== 2'd0 || link_fail_o !== 1'b0) begin
            bad++;
            $display("FAIL restart_beats_timeout: tx=%b retry=%0d fail=%b, required 0 0 0",
                     soft_reset_tx_o, retry_cnt_o, link_fail_o);
        end
        @(negedge clk);
        total++;
        if (soft_reset_tx_o !== 1'b1 || retry_cnt_o !== 2'd0) begin
            bad++;
            $display("FAIL restart_then_txrst: tx=%b retry=%0d, required 1 0", soft_reset_tx_o, retry_cnt_o);
        end
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        sys_rst     = 1'b1;
        restart     = 1'b0;
        lane_en     = 2'b00;
        data_valid  = 2'b11;
        tx_block    = 1'b0;
        rx_block    = 2'b00;
        tx_rst_done = 2'b00;
        rx_rst_done = 2'b00;
        tx_ctr      = 0;
        rx_ctr[0]   = 0;
        rx_ctr[1]   = 0;
        test_reset();
        test_bringup();
        test_loss_63();
        test_loss_64();
`ifdef TENG_LINK_STATS_EN
        test_stats();
`endif
        test_lane_mask();
        test_timeout_fail();
        test_restart_in_fail();
        test_restart_vs_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
